seq_player: RTL and testbench

//   Plays back the stored Simon Says colour sequence on the four LEDs.

---
 rtl/simon_pkg.sv | 38 +++
 rtl/seq_phase_timer.sv | 37 +++
 rtl/seq_player.sv | 178 +++++++++++++++++
 tb/tb_seq_player.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// ---------------------------------------------------------------------------
// simon_pkg
//   Shared definitions for the Simon Says blocks: colour codes, the playback
//   state encoding, the maximum sequence length and the colour-to-LED decode.
//   No ports (package).
// ---------------------------------------------------------------------------
package simon_pkg;

    // 2-bit colour codes as stored in the sequence word
    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] GRN = 2'd1;
    localparam logic [1:0] BLU = 2'd2;
    localparam logic [1:0] YEL = 2'd3;

    // The 32-bit sequence word holds 16 two-bit steps
    localparam int MAX_STEPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } play_state_t;

    // One-hot LED pattern for a colour code
    function automatic logic [3:0] colour_onehot(input logic [1:0] code);
        logic [3:0] pattern;
        case (code)
            RED:     pattern = 4'b0001;
            GRN:     pattern = 4'b0010;
            BLU:     pattern = 4'b0100;
            YEL:     pattern = 4'b1000;
            default: pattern = 4'b0000;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// ---------------------------------------------------------------------------
// seq_phase_timer
//   Loadable down-counter that times one ON or GAP phase. A load takes
//   priority; otherwise the count decrements and holds at zero, so it never
//   wraps.
// Ports
//   clk       in   1      system clock
//   rst_n     in   1      asynchronous active-low reset (count -> 0)
//   load      in   1      load load_val on the next edge
//   load_val  in   CNT_W  value to load (phase length minus one)
//   zero      out  1      count is zero (last cycle of the phase)
// ---------------------------------------------------------------------------
module seq_phase_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/seq_player.sv
// ---------------------------------------------------------------------------
// seq_player
//   Plays the stored Simon Says colour sequence on four LEDs. On start the
//   sequence word and the clamped level are snapshotted; the first lvl steps
//   are then shown, each lit for an ON phase and followed by a dark GAP
//   phase, after which done pulses for one cycle.
//
//   All outputs are registered from the current FSM state, so they trail the
//   state register by one cycle: start sampled at edge N shows the first LED
//   after edge N+1, and done is high for the single cycle after the DONE
//   state.
//
//   Optional feature macro: SEQ_PLAYER_SPEEDUP_EN
//     defined   : when lvl >= 8 each ON phase lasts max(ON_CYCLES>>1, 1) cycles
//     undefined : ON phase is always ON_CYCLES cycles
//
// Ports
//   clk       in   1   system clock
//   rst_n     in   1   asynchronous active-low reset
//   start     in   1   one-cycle playback request, only honoured in IDLE
//   level     in   5   steps to play; 0 = none, values above 16 clamp to 16
//   seq_in    in   32  sequence word, step k in bits [2k+1:2k]
//   busy      out  1   high while steps are playing
//   done      out  1   one-cycle pulse at the end of playback
//   led       out  4   one-hot colour of the current step, 0 when dark
//   step_idx  out  4   index of the step currently shown
// ---------------------------------------------------------------------------
module seq_player
    import simon_pkg::*;
#(
    parameter int CNT_W      = 24,
    parameter int ON_CYCLES  = 12_500_000,
    parameter int GAP_CYCLES = 6_250_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  level,
    input  logic [31:0] seq_in,
    output logic        busy,
    output logic        done,
    output logic [3:0]  led,
    output logic [3:0]  step_idx
);

    // Timer load values are phase length minus one: the phase ends on the
    // cycle the timer reads zero.
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
`ifdef SEQ_PLAYER_SPEEDUP_EN
    localparam int               ON_FAST      = ((ON_CYCLES >> 1) < 1) ? 1 : (ON_CYCLES >> 1);
    localparam logic [CNT_W-1:0] ON_FAST_LOAD = CNT_W'(ON_FAST - 1);
`endif

    play_state_t      state;
    logic [31:0]      snapshot;
    logic [4:0]       lvl;
    logic [3:0]       cur_step;

    logic [4:0]       level_clamped;
    logic             last_step;
    logic [CNT_W-1:0] on_load_start;
    logic [CNT_W-1:0] on_load_run;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    assign level_clamped = (level > 5'(MAX_STEPS)) ? 5'(MAX_STEPS) : level;
    assign last_step     = ({1'b0, cur_step} == (lvl - 5'd1));

    // ON length is chosen from the incoming level at start and from the
    // latched lvl afterwards, since lvl is not yet valid at the start edge.
`ifdef SEQ_PLAYER_SPEEDUP_EN
    assign on_load_start = (level_clamped >= 5'd8) ? ON_FAST_LOAD : ON_LOAD;
    assign on_load_run   = (lvl >= 5'd8) ? ON_FAST_LOAD : ON_LOAD;
`else
    assign on_load_start = ON_LOAD;
    assign on_load_run   = ON_LOAD;
`endif

    // Timer reloads on every phase entry; in all other cycles it counts down
    // and rests at zero.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (start && (level_clamped != 5'd0)) begin
                    tmr_load = 1'b1;
                    tmr_val  = on_load_start;
                end
            end
            ON: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (tmr_zero && !last_step) begin
                    tmr_load = 1'b1;
                    tmr_val  = on_load_run;
                end
            end
            default: begin
            end
        endcase
    end

    seq_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Control FSM with snapshot, level and step registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            snapshot <= '0;
            lvl      <= '0;
            cur_step <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshot <= seq_in;
                        lvl      <= level_clamped;
                        cur_step <= '0;
                        state    <= (level_clamped == 5'd0) ? DONE : ON;
                    end
                end
                ON: begin
                    if (tmr_zero) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        if (last_step) begin
                            cur_step <= '0;
                            state    <= DONE;
                        end else begin
                            cur_step <= cur_step + 4'd1;
                            state    <= ON;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered outputs decoded from the current state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_idx <= '0;
        end else begin
            led      <= (state == ON) ? colour_onehot(snapshot[{cur_step, 1'b0} +: 2]) : 4'b0000;
            busy     <= (state == ON) || (state == GAP);
            done     <= (state == DONE);
            step_idx <= ((state == ON) || (state == GAP)) ? cur_step : 4'd0;
        end
    end

endmodule

// File: tb/tb_seq_player.sv
// ---------------------------------------------------------------------------
// tb_seq_player
//   Directed bench for seq_player with ON_CYCLES=4, GAP_CYCLES=2. Inputs are
//   driven on the falling edge and outputs sampled on the falling edge, so
//   sample i is the state after rising edge N+1+i where N is the edge that
//   sampled start.
// ---------------------------------------------------------------------------
module tb_seq_player;

    localparam int ON_C  = 4;
    localparam int GAP_C = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [4:0]  level  = '0;
    logic [31:0] seq_in = '0;
    logic        busy;
    logic        done;
    logic [3:0]  led;
    logic [3:0]  step_idx;

    int checks = 0;
    int errors = 0;

    // Hand-derived LED trace for seq 0x000000E4, level 4 (colours 0,1,2,3)
    logic [3:0] led_tab [0:23] = '{
        4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
        4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
        4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
        4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000
    };

    always #5 clk = ~clk;

    seq_player #(
        .CNT_W      (24),
        .ON_CYCLES  (ON_C),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .level    (level),
        .seq_in   (seq_in),
        .busy     (busy),
        .done     (done),
        .led      (led),
        .step_idx (step_idx)
    );

    // Expected {led, busy, done, step_idx} for sample i of a playback
    function automatic logic [9:0] exp_word(input logic [31:0] seq, input int lvl,
                                            input int on_len, input int i);
        int         period;
        int         step;
        int         ph;
        logic [3:0] l;
        logic [1:0] code;
        period = on_len + GAP_C;
        if (i < lvl * period) begin
            step = i / period;
            ph   = i % period;
            code = 2'((seq >> (2 * step)) & 32'd3);
            l    = (ph < on_len) ? (4'b0001 << code) : 4'b0000;
            return {l, 1'b1, 1'b0, 4'(step)};
        end else if (i == lvl * period) begin
            return {4'b0000, 1'b0, 1'b1, 4'd0};
        end
        return 10'd0;
    endfunction

    function automatic logic [9:0] obs_word();
        return {led, busy, done, step_idx};
    endfunction

    task automatic pulse_start(input logic [31:0] seq, input logic [4:0] lv);
        @(negedge clk);
        seq_in = seq;
        level  = lv;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (obs_word() !== 10'd0) begin
            errors++;
            $display("FAIL reset_hold: got %b required %b", obs_word(), 10'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_word() !== 10'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %b required %b", i, obs_word(), 10'd0);
            end
        end
    endtask

    task automatic test_basic;
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        pulse_start(32'h0000_00E4, 5'd4);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) done_cnt++;
            if (i < 24) begin
                checks++;
                if (led !== led_tab[i] || busy !== 1'b1 || step_idx !== 4'(i / 6)) begin
                    errors++;
                    $display("FAIL basic_trace cycle %0d: got led=%b busy=%b step=%0d required led=%b busy=1 step=%0d",
                             i, led, busy, step_idx, led_tab[i], i / 6);
                end
            end else if (i == 24) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || led !== 4'b0000) begin
                    errors++;
                    $display("FAIL basic_done: got done=%b busy=%b led=%b required done=1 busy=0 led=0000",
                             done, busy, led);
                end
            end
        end
        checks++;
        if (busy_cnt != 24) begin
            errors++;
            $display("FAIL basic_busy_len: got %0d required 24", busy_cnt);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_level_zero;
        pulse_start(32'h0000_00E4, 5'd0);
        checks++;
        if (obs_word() !== 10'd0) begin
            errors++;
            $display("FAIL zero_before: got %b required %b", obs_word(), 10'd0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_word() !== exp_word(32'h0, 0, ON_C, i)) begin
                errors++;
                $display("FAIL zero_level cycle %0d: got %b required %b",
                         i, obs_word(), exp_word(32'h0, 0, ON_C, i));
            end
        end
    endtask

    task automatic test_clamp;
        pulse_start(32'h1B1B_1B1B, 5'd20);
        for (int i = 0; i < 16 * 6 + 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_word() !== exp_word(32'h1B1B_1B1B, 16, ON_C, i)) begin
                errors++;
                $display("FAIL clamp cycle %0d: got %b required %b",
                         i, obs_word(), exp_word(32'h1B1B_1B1B, 16, ON_C, i));
            end
        end
    endtask

    task automatic test_ignore_start;
        int done_cnt;
        done_cnt = 0;
        pulse_start(32'h0000_00E4, 5'd4);
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            checks++;
            if (obs_word() !== exp_word(32'h0000_00E4, 4, ON_C, i)) begin
                errors++;
                $display("FAIL ignore_start cycle %0d: got %b required %b",
                         i, obs_word(), exp_word(32'h0000_00E4, 4, ON_C, i));
            end
            // Disturb inputs in the middle of step 1
            if (i == 7) begin
                seq_in = 32'hFFFF_FFFF;
                level  = 5'd9;
                start  = 1'b1;
            end else if (i == 8) begin
                start  = 1'b0;
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_async_reset;
        pulse_start(32'h0000_00E4, 5'd4);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (led !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got led=%b busy=%b required led=0001 busy=1", led, busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_word() !== 10'd0) begin
            errors++;
            $display("FAIL areset_async: got %b required %b", obs_word(), 10'd0);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (obs_word() !== 10'd0) begin
                errors++;
                $display("FAIL areset_idle cycle %0d: got %b required %b", i, obs_word(), 10'd0);
            end
        end
        // A fresh single-step playback after reset
        pulse_start(32'h0000_0003, 5'd1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            checks++;
            if (obs_word() !== exp_word(32'h0000_0003, 1, ON_C, i)) begin
                errors++;
                $display("FAIL areset_restart cycle %0d: got %b required %b",
                         i, obs_word(), exp_word(32'h0000_0003, 1, ON_C, i));
            end
        end
    endtask

    task automatic test_speedup;
        int on8;
`ifdef SEQ_PLAYER_SPEEDUP_EN
        on8 = 2;
`else
        on8 = 4;
`endif
        pulse_start(32'h0000_E4E4, 5'd8);
        for (int i = 0; i < 8 * (on8 + GAP_C) + 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_word() !== exp_word(32'h0000_E4E4, 8, on8, i)) begin
                errors++;
                $display("FAIL speed_l8 cycle %0d: got %b required %b",
                         i, obs_word(), exp_word(32'h0000_E4E4, 8, on8, i));
            end
        end
        pulse_start(32'h0000_1B1B, 5'd7);
        for (int i = 0; i < 7 * (ON_C + GAP_C) + 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_word() !== exp_word(32'h0000_1B1B, 7, ON_C, i)) begin
                errors++;
                $display("FAIL speed_l7 cycle %0d: got %b required %b",
                         i, obs_word(), exp_word(32'h0000_1B1B, 7, ON_C, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_zero();
        test_clamp();
        test_ignore_start();
        test_async_reset();
        test_speedup();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
